// File: rtl/uart_pkg.sv
// Shared UART constants and the reset-divisor calculation for the baud generator.
package uart_pkg;

  localparam int unsigned DIV_W_DEF  = 16;
  localparam int unsigned FRAC_W_DEF = 4;
  localparam int unsigned OS_LEGAL_A = 8;
  localparam int unsigned OS_LEGAL_B = 16;

  function automatic bit os_is_legal(int unsigned os);
    return (os == OS_LEGAL_A) || (os == OS_LEGAL_B);
  endfunction

  function automatic int unsigned calc_def_int(int unsigned clk_rate, int unsigned baud,
                                               int unsigned os);
    return clk_rate / (baud * os);
  endfunction

  // Fractional part of clk_rate/(baud*os) in units of 1/2^frac_w.
  function automatic int unsigned calc_def_frac(int unsigned clk_rate, int unsigned baud,
                                                int unsigned os, int unsigned frac_w);
    longint unsigned num;
    num = 64'(clk_rate) << frac_w;
    return 32'((num / 64'(baud * os)) % (64'd1 << frac_w));
  endfunction

endpackage

// File: rtl/frac_accum.sv
// Fractional phase accumulator: the carry out stretches the current period by one clock.
module frac_accum
  import uart_pkg::*;
#(
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_extend_c
);

  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W:0]   w_sum;

  assign w_sum      = {1'b0, r_acc} + {1'b0, i_frac};
  assign o_extend_c = w_sum[FRAC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= w_sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Programmable oversample/baud tick generator with fractional divider, boundary-safe
// divisor reload, enable/hold and resync.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE   = 15360000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_W        = DIV_W_DEF,
  parameter int unsigned FRAC_W       = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              oversampling_tick,
  output logic              baud_tick,
  output logic              load_pending,
  output logic              cfg_err
);

  localparam int unsigned CNT_W      = DIV_W + 1;
  localparam int unsigned BIT_W      = $clog2(OVERSAMPLE);
  localparam int unsigned DEF_INT_U  = calc_def_int(CLOCK_RATE, DEFAULT_BAUD, OVERSAMPLE);
  localparam int unsigned DEF_FRAC_U = calc_def_frac(CLOCK_RATE, DEFAULT_BAUD, OVERSAMPLE,
                                                     FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_INT_U);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_FRAC_U);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(OVERSAMPLE - 1);

  if (!os_is_legal(OVERSAMPLE)) begin : g_bad_oversample
    $error("baud_gen_frac: OVERSAMPLE must be 8 or 16");
  end
  if ((DEF_INT_U < 2) || (64'(DEF_INT_U) >= (64'd1 << DIV_W))) begin : g_bad_default
    $error("baud_gen_frac: default integer divisor must lie in [2, 2^DIV_W)");
  end

  logic [DIV_W-1:0]  r_div_int;
  logic [FRAC_W-1:0] r_div_frac;
  logic [DIV_W-1:0]  r_pend_int;
  logic [FRAC_W-1:0] r_pend_frac;
  logic [CNT_W-1:0]  r_os_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;

  logic              w_extend;
  logic [CNT_W-1:0]  w_period;
  logic              w_load_ok;
  logic              w_term;
  logic              w_boundary;
  logic              w_apply;
  logic              w_acc_clr;

  assign w_load_ok  = div_load && (div_int >= DIV_W'(2));
  assign w_period   = {1'b0, r_div_int} + CNT_W'(w_extend);
  // >= keeps an over-long count (divisor shrunk while held) from running away.
  assign w_term     = enable && !resync && (r_os_cnt >= (w_period - CNT_W'(1)));
  assign w_boundary = w_term && (r_bit_cnt == BIT_LAST);
  assign w_apply    = load_pending && (w_boundary || !enable || resync);
  assign w_acc_clr  = resync || w_apply;

  frac_accum #(.FRAC_W(FRAC_W)) u_frac_accum (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_acc_clr),
    .i_step     (w_term),
    .i_frac     (r_div_frac),
    .o_extend_c (w_extend)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_int         <= DEF_INT;
      r_div_frac        <= DEF_FRAC;
      r_pend_int        <= '0;
      r_pend_frac       <= '0;
      r_os_cnt          <= '0;
      r_bit_cnt         <= '0;
      oversampling_tick <= 1'b0;
      baud_tick         <= 1'b0;
      load_pending      <= 1'b0;
      cfg_err           <= 1'b0;
    end else begin
      oversampling_tick <= w_term;
      baud_tick         <= w_boundary;
      cfg_err           <= div_load && !w_load_ok;

      if (resync) begin
        r_os_cnt  <= '0;
        r_bit_cnt <= '0;
      end else if (enable) begin
        if (w_term) begin
          r_os_cnt  <= '0;
          r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + BIT_W'(1);
        end else begin
          r_os_cnt <= r_os_cnt + CNT_W'(1);
        end
      end

      // A legal load alongside resync bypasses the pending stage entirely.
      if (resync && w_load_ok) begin
        r_div_int    <= div_int;
        r_div_frac   <= div_frac;
        load_pending <= 1'b0;
      end else begin
        if (w_apply) begin
          r_div_int  <= r_pend_int;
          r_div_frac <= r_pend_frac;
        end
        if (w_load_ok) begin
          r_pend_int   <= div_int;
          r_pend_frac  <= div_frac;
          load_pending <= 1'b1;
        end else if (w_apply) begin
          load_pending <= 1'b0;
        end
      end
    end
  end

endmodule
